// File: rtl/result_stage_p.sv
// result_stage_p: two-entry skid buffer registering an adder/subtractor
// result with its carry/zero/overflow flags, plus an overflow pop counter.
// Optional feature: define STICKY_FLAGS_EN to enable the sticky_ovf/sticky_cout
// status bits; without it they are tied low and clr_sticky is ignored.
module result_stage_p #(
    parameter int unsigned SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] SUM,
    input  logic            cout,
    input  logic            ZERO_FLAG,
    input  logic            OVERFLOW_FLAG,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] RESULT,
    output logic            COUT,
    output logic            ZERO,
    output logic            OVERFLOW,
    output logic            NEG,
    output logic [7:0]      ovf_count,
    input  logic            clr_sticky,
    output logic            sticky_ovf,
    output logic            sticky_cout
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [SIZE-1:0] sum;
        logic            c;
        logic            z;
        logic            o;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t in_e;
    logic   push, pop;

    assign in_e = {SUM, cout, ZERO_FLAG, OVERFLOW_FLAG};

    // Handshakes, next occupancy state and entry movement
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            in_ready  = (state_q != S_FULL);
            out_valid = (state_q != S_EMPTY);
        end
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = in_e;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (push && pop) begin
                    head_d = in_e;
                end else if (push) begin
                    tail_d  = in_e;
                    state_d = S_FULL;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (rst) begin
            state_d = S_EMPTY;
        end
    end

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    // Head presentation, forced to zero when empty
    always_comb begin
        RESULT   = '0;
        COUT     = 1'b0;
        ZERO     = 1'b0;
        OVERFLOW = 1'b0;
        NEG      = 1'b0;
        if (state_q != S_EMPTY) begin
            RESULT   = head_q.sum;
            COUT     = head_q.c;
            ZERO     = head_q.z;
            OVERFLOW = head_q.o;
            NEG      = head_q.sum[SIZE-1];
        end
    end

    // Saturating count of popped overflow entries
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (pop && head_q.o && (ovf_count != CNT_W'(CNT_MAX))) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

`ifdef STICKY_FLAGS_EN
    // Sticky status: a setting pop wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf  <= 1'b0;
            sticky_cout <= 1'b0;
        end else begin
            if (clr_sticky) begin
                sticky_ovf  <= 1'b0;
                sticky_cout <= 1'b0;
            end
            if (pop && head_q.o) begin
                sticky_ovf <= 1'b1;
            end
            if (pop && head_q.c) begin
                sticky_cout <= 1'b1;
            end
        end
    end
`else
    logic unused_clr_sticky;
    assign unused_clr_sticky = clr_sticky;
    assign sticky_ovf        = 1'b0;
    assign sticky_cout       = 1'b0;
`endif

endmodule

// File: tb/tb_result_stage_p.sv
// tb_result_stage_p: directed scenarios plus randomized traffic for
// result_stage_p, checked against a queue-based model of the buffer.
module tb_result_stage_p;

    localparam int unsigned SIZE = 32;
`ifdef STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] SUM = '0;
    logic            cout = 1'b0;
    logic            ZERO_FLAG = 1'b0;
    logic            OVERFLOW_FLAG = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SIZE-1:0] RESULT;
    logic            COUT, ZERO, OVERFLOW, NEG;
    logic [7:0]      ovf_count;
    logic            clr_sticky = 1'b0;
    logic            sticky_ovf, sticky_cout;

    result_stage_p #(.SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .SUM(SUM), .cout(cout), .ZERO_FLAG(ZERO_FLAG), .OVERFLOW_FLAG(OVERFLOW_FLAG),
        .out_valid(out_valid), .out_ready(out_ready), .RESULT(RESULT),
        .COUT(COUT), .ZERO(ZERO), .OVERFLOW(OVERFLOW), .NEG(NEG),
        .ovf_count(ovf_count), .clr_sticky(clr_sticky),
        .sticky_ovf(sticky_ovf), .sticky_cout(sticky_cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0] sum;
        bit              c;
        bit              z;
        bit              o;
    } item_t;

    item_t q[$];
    int    m_cnt = 0;
    bit    m_sovf = 1'b0;
    bit    m_scout = 1'b0;
    bit    checking = 1'b0;
    int    checks = 0;
    int    failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the model, advance the model
    task automatic step(input bit r, input bit iv, input logic [SIZE-1:0] s,
                        input bit c, input bit z, input bit o,
                        input bit ordy, input bit clr);
        item_t h;
        bit    e_ir, e_ov, do_push, do_pop;
        @(negedge clk);
        rst = r; in_valid = iv; SUM = s; cout = c; ZERO_FLAG = z;
        OVERFLOW_FLAG = o; out_ready = ordy; clr_sticky = clr;
        #1;
        e_ir = !r && (q.size() < 2);
        e_ov = !r && (q.size() > 0);
        h = '{sum: '0, c: 1'b0, z: 1'b0, o: 1'b0};
        if (q.size() > 0) h = q[0];
        if (checking) begin
            check_eq("in_ready", 32'(in_ready), 32'(e_ir));
            check_eq("out_valid", 32'(out_valid), 32'(e_ov));
            check_eq("RESULT", RESULT, h.sum);
            check_eq("COUT", 32'(COUT), 32'(h.c));
            check_eq("ZERO", 32'(ZERO), 32'(h.z));
            check_eq("OVERFLOW", 32'(OVERFLOW), 32'(h.o));
            check_eq("NEG", 32'(NEG), 32'(h.sum[SIZE-1]));
            check_eq("ovf_count", 32'(ovf_count), 32'(m_cnt));
            check_eq("sticky_ovf", 32'(sticky_ovf), 32'(m_sovf));
            check_eq("sticky_cout", 32'(sticky_cout), 32'(m_scout));
        end
        do_push = iv && e_ir;
        do_pop  = ordy && e_ov;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_cnt = 0; m_sovf = 1'b0; m_scout = 1'b0;
        end else begin
            if (STICKY && clr) begin
                m_sovf = 1'b0; m_scout = 1'b0;
            end
            if (do_pop) begin
                if (h.o && m_cnt < 255) m_cnt++;
                if (STICKY && h.o) m_sovf = 1'b1;
                if (STICKY && h.c) m_scout = 1'b1;
                void'(q.pop_front());
            end
            if (do_push) q.push_back('{sum: s, c: c, z: z, o: o});
        end
        checking = 1'b1;
    endtask

    initial begin
        // reset
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_ovf_count", 32'(ovf_count), 32'd0);

        // single push of 5 with carry, then drain
        step(0, 1, 32'h5, 1, 0, 0, 1, 0);
        #2;
        check_eq("p5_out_valid", 32'(out_valid), 32'd1);
        check_eq("p5_result", RESULT, 32'h5);
        check_eq("p5_cout", 32'(COUT), 32'd1);
        check_eq("p5_neg", 32'(NEG), 32'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        check_eq("p5_empty_valid", 32'(out_valid), 32'd0);
        check_eq("p5_empty_result", RESULT, 32'h0);
        check_eq("p5_empty_cout", 32'(COUT), 32'd0);

        // fill to FULL under backpressure; third push refused
        step(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        step(0, 1, 32'h0, 0, 1, 0, 0, 0);
        #2;
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        step(0, 1, 32'h123, 0, 0, 0, 0, 0);
        #2;
        check_eq("full_hold_result", RESULT, 32'hFFFF_FFFF);
        check_eq("full_hold_neg", 32'(NEG), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        check_eq("full_drained", 32'(out_valid), 32'd0);

        // ONE with simultaneous push and pop
        step(0, 1, 32'h3, 0, 0, 0, 0, 0);
        step(0, 1, 32'hA, 0, 0, 0, 1, 0);
        #2;
        check_eq("pp_result", RESULT, 32'hA);
        check_eq("pp_in_ready", 32'(in_ready), 32'd1);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        check_eq("pp_empty", 32'(out_valid), 32'd0);

        // 300 overflow pops saturate the counter
        for (int i = 0; i < 300; i++) step(0, 1, 32'(i), 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        check_eq("ovf_saturate", 32'(ovf_count), 32'd255);

        // sticky: pop with overflow during clear, then clear alone
        step(0, 1, 32'h7, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        #2;
        check_eq("sticky_set_wins", 32'(sticky_ovf), 32'(STICKY));
        step(0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        check_eq("sticky_cleared", 32'(sticky_ovf), 32'd0);

        // reset while FULL
        step(0, 1, 32'h11, 0, 0, 1, 0, 0);
        step(0, 1, 32'h22, 0, 0, 1, 0, 0);
        step(1, 1, 32'h33, 0, 0, 0, 1, 0);
        #2;
        check_eq("rstf_out_valid", 32'(out_valid), 32'd0);
        check_eq("rstf_ovf_count", 32'(ovf_count), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rstf_in_ready", 32'(in_ready), 32'd1);
        check_eq("rstf_discarded", 32'(out_valid), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), 1'($urandom), $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(3) != 0), ($urandom_range(7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_stage_p.md
RESULT_STAGE_P -- requirements
Module: result_stage_p

Interface
REQ-001 SHALL have parameter SIZE, default 32, datapath width of the subtractor/adder result being buffered.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream result (SUM/cout/flags) is valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept an upstream result this cycle.
REQ-006 SHALL have port SUM  input  SIZE  subtractor/adder result.
REQ-007 SHALL have ports cout, ZERO_FLAG, OVERFLOW_FLAG, each an input of width 1, carrying the upstream carry-out, zero flag and overflow flag.
REQ-008 SHALL have port out_valid  output  1  head entry is presented downstream.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the head entry this cycle.
REQ-010 SHALL have port RESULT  output  SIZE  head entry result.
REQ-011 SHALL have ports COUT, ZERO, OVERFLOW, NEG, each an output of width 1, carrying the head entry flags; NEG is RESULT[SIZE-1].
REQ-012 SHALL have port ovf_count  output  8  number of popped entries with OVERFLOW=1.
REQ-013 SHALL have port clr_sticky  input  1  clears the sticky status bits.
REQ-014 SHALL have ports sticky_ovf and sticky_cout, each an output of width 1, holding sticky overflow and carry status.

Function
REQ-015 SHALL implement a 2-entry FIFO (skid buffer) with states EMPTY, ONE and FULL, tracked by an occupancy count of 0, 1 or 2.
REQ-016 SHALL assert in_ready when rst is 0 and the state is not FULL; a push occurs when in_valid and in_ready are both 1.
REQ-017 SHALL assert out_valid exactly when the state is not EMPTY; a pop occurs when out_valid and out_ready are both 1.
REQ-018 SHALL register each pushed entry as {SUM, cout, ZERO_FLAG, OVERFLOW_FLAG}, and SHALL derive NEG from the stored SUM.
REQ-019 SHALL have a latency of 1 cycle from push to out_valid; there SHALL be no combinational path from in_* to out_*.
REQ-020 SHALL make these state transitions:
- EMPTY + push -> ONE.
- ONE + push without pop -> FULL.
- ONE + pop without push -> EMPTY.
- ONE + push and pop -> ONE, with the new entry becoming head the next cycle.
- FULL + pop -> ONE, with the second entry becoming head.
- FULL cannot push, since in_ready is 0.
REQ-021 SHALL preserve order: entries are presented in push order, and none is lost or duplicated under any in_valid/out_ready pattern.
REQ-022 SHALL hold RESULT and all flags stable while out_valid=1 and out_ready=0.
REQ-023 SHALL drive RESULT, COUT, ZERO, OVERFLOW and NEG to 0 when the state is EMPTY.
REQ-024 SHALL increment ovf_count by 1 on each pop whose OVERFLOW=1, saturating at 255 with no wrap.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set the state to EMPTY, set ovf_count=0, set sticky_ovf=0 and sticky_cout=0, and discard buffered entries.
REQ-026 SHALL hold in_ready=0 and out_valid=0 in any cycle where rst=1, including reset asserted mid-operation; pushes and pops SHALL be ignored during that cycle.

Configuration
REQ-027 SHALL, with macro STICKY_FLAGS_EN defined, set sticky_ovf on a pop with OVERFLOW=1 and set sticky_cout on a pop with COUT=1; clr_sticky=1 SHALL clear both bits next edge, with set winning over clear in the same cycle.
REQ-028 SHALL, without STICKY_FLAGS_EN, keep the sticky_ovf, sticky_cout and clr_sticky ports, tie sticky_ovf and sticky_cout to 0, and ignore clr_sticky; all other behaviour SHALL be unchanged.

Verification
REQ-029 SHALL cover: reset, then push SUM=0x00000005 with cout=1 and out_ready=1 -> next cycle out_valid=1, RESULT=5, COUT=1, NEG=0; the following cycle state is EMPTY with all outputs 0.
REQ-030 SHALL cover: out_ready=0, push 0xFFFFFFFF then 0x0 -> in_ready=0 after 2 pushes; a third in_valid is not accepted; RESULT holds 0xFFFFFFFF with NEG=1.
REQ-031 SHALL cover: state ONE, simultaneous push 0xA and pop of 0x3 -> 0x3 consumed, next cycle RESULT=0xA, state remains ONE.
REQ-032 SHALL cover: 300 pops with OVERFLOW=1 -> ovf_count=255 with no wrap.
REQ-033 SHALL cover, with STICKY_FLAGS_EN defined: pop with OVERFLOW=1 while clr_sticky=1 -> sticky_ovf=1; then clr_sticky alone -> sticky_ovf=0; without the macro, sticky_ovf stays 0 throughout.
REQ-034 SHALL cover: rst=1 while FULL -> next cycle out_valid=0, ovf_count=0, and entries discarded; in_ready=1 once rst=0.
